mul_int: RTL and testbench

Iterative shift-add integer multiplier. It is the companion to the team's iterative restoring divider. Given two DSZ-bit operands, it produces a 2·DSZ-bit product over DSZ+2 cycles, in either unsigned or two's-complement signed mode, and uses a start/busy/done handshake. It sits beside the divider in the ALU slow path and serves the multiply opcodes; the core stalls on `busy`.

---
 rtl/mul_int_pkg.sv | 13 +
 rtl/mul_int.sv | 117 +++++++++++
 tb/tb_mul_int.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_int_pkg.sv
// Shared ALU slow-path definitions used by the iterative multiplier.
package mul_int_pkg;

    // Multiplier sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } mul_st_t;

    localparam int unsigned MUL_DSZ_DEFAULT = 32;

endpackage

// File: rtl/mul_int.sv
// Iterative shift-add integer multiplier, unsigned or two's-complement,
// DSZ+2 cycles per product with a start/busy/done handshake.
module mul_int
    import mul_int_pkg::*;
#(
    parameter int unsigned DSZ = MUL_DSZ_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           sgn,
    input  logic [DSZ-1:0] x,
    input  logic [DSZ-1:0] y,
    output logic           busy,
    output logic           done,
    output logic [DSZ-1:0] hi,
    output logic [DSZ-1:0] lo
);

    localparam int unsigned CW = $clog2(DSZ);
    localparam logic [CW-1:0] I_LAST = CW'(DSZ - 1);

    mul_st_t          state_q, state_d;
    logic [2*DSZ:0]   acc_q, acc_d;
    logic [DSZ-1:0]   mx_q, mx_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    i_q, i_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DSZ-1:0]   hi_q, hi_d;
    logic [DSZ-1:0]   lo_q, lo_d;

    logic [DSZ-1:0]   x_mag, y_mag;
    logic [DSZ:0]     t;
    logic [2*DSZ-1:0] prod, p;

    // Operand magnitudes, single DSZ+1-bit add step and final sign fix-up.
    always_comb begin
        x_mag = (sgn & x[DSZ-1]) ? -x : x;
        y_mag = (sgn & y[DSZ-1]) ? -y : y;
        t     = acc_q[2*DSZ:DSZ] + (acc_q[0] ? {1'b0, mx_q} : '0);
        prod  = acc_q[2*DSZ-1:0];
        p     = neg_q ? -prod : prod;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mx_d    = mx_q;
        neg_d   = neg_q;
        i_d     = i_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mx_d    = x_mag;
                    neg_d   = sgn & (x[DSZ-1] ^ y[DSZ-1]);
                    acc_d   = {{(DSZ+1){1'b0}}, y_mag};
                    i_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = {1'b0, t, acc_q[DSZ-1:1]};
                if (i_q == I_LAST) begin
                    // Clear rather than wrap so the counter is ready for the next run.
                    i_d     = '0;
                    state_d = SIGN;
                end else begin
                    i_d = i_q + CW'(1);
                end
            end
            SIGN: begin
                {hi_d, lo_d} = p;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Datapath registers; contents are don't-care until loaded by start.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        mx_q  <= mx_d;
        neg_q <= neg_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_int.sv
// Self-checking bench for mul_int: vector table, random model vectors and
// handshake/reset sequences, with a queue of expected products.
module tb_mul_int;

    localparam int unsigned W   = 32;
    localparam int          LAT = W + 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic          sgn;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    mul_int #(.DSZ(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sgn  (sgn),
        .x    (x),
        .y    (y),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          s;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [63:0]   e;
    } vec_t;

    vec_t        vecs [8];
    logic [63:0] expq [$];
    logic [63:0] last_res;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sp;
        if (s) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return 64'(sp);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called at a negedge: drive a request and record its expected product.
    task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input logic [63:0] e);
        expq.push_back(e);
        sgn   = s;
        x     = a;
        y     = b;
        start = 1'b1;
    endtask

    // Waits for done, checking busy, output stability, latency and result.
    task automatic wait_done(input string name, input bit hold, input bit pokes);
        int          n;
        bit          got;
        logic [63:0] e;
        n   = 0;
        got = 1'b0;
        while (!got && n < 3 * LAT) begin
            @(negedge clk);
            n++;
            if (!hold) start = 1'b0;
            if (pokes && (n == 5 || n == 20)) begin
                start = 1'b1;
                x     = 32'h0000_0003;
                y     = 32'h0000_0005;
            end
            if (n == 1)  chk({name, " busy@1"}, {62'b0, busy, done}, 64'd2);
            if (n == 10) chk({name, " hold@10"}, {hi, lo}, last_res);
            if (done) begin
                got = 1'b1;
                chk({name, " latency"}, 64'(n), 64'(LAT));
                chk({name, " busy@done"}, {63'b0, busy}, 64'd0);
                if (expq.size() == 0) begin
                    chk({name, " unexpected done"}, 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    chk({name, " product"}, {hi, lo}, e);
                    last_res = e;
                end
            end
        end
        if (!got) chk({name, " timeout"}, 64'(n), 64'(LAT));
    endtask

    // Runs k idle cycles and requires no done pulse in them.
    task automatic idle_check(input string name, input int k);
        int pulses;
        pulses = 0;
        start  = 1'b0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({name, " no extra done"}, 64'(pulses), 64'd0);
        chk({name, " idle busy"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        int           n;

        total    = 0;
        bad      = 0;
        last_res = '0;
        rst      = 1'b1;
        start    = 1'b0;
        sgn      = 1'b0;
        x        = '0;
        y        = '0;

        vecs[0] = '{s: 1'b0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, e: 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{s: 1'b1, a: 32'hFFFF_FFFD, b: 32'h0000_0007, e: 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2] = '{s: 1'b0, a: 32'hFFFF_FFFD, b: 32'h0000_0007, e: 64'h0000_0006_FFFF_FFEB};
        vecs[3] = '{s: 1'b1, a: 32'h8000_0000, b: 32'h8000_0000, e: 64'h4000_0000_0000_0000};
        vecs[4] = '{s: 1'b1, a: 32'h8000_0000, b: 32'h0000_0001, e: 64'hFFFF_FFFF_8000_0000};
        vecs[5] = '{s: 1'b0, a: 32'h0000_0000, b: 32'h1234_5678, e: 64'h0};
        vecs[6] = '{s: 1'b1, a: 32'h0000_0007, b: 32'hFFFF_FFFD, e: 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[7] = '{s: 1'b1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, e: 64'h0000_0000_0000_0001};

        repeat (3) @(negedge clk);
        chk("reset outputs", {30'b0, busy, done, hi ^ lo, lo}, 64'd0);
        chk("reset hi", {32'b0, hi}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            launch(vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].e);
            wait_done($sformatf("vec%0d", v), 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d single done", v), {63'b0, done}, 64'd0);
        end

        for (int r = 0; r < 8; r++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'(r & 1);
            launch(rs, ra, rb, model(rs, ra, rb));
            wait_done($sformatf("rnd%0d", r), 1'b0, 1'b0);
        end

        // start pulses while busy must be ignored.
        @(negedge clk);
        launch(1'b0, 32'h0001_0000, 32'h0001_0001, 64'h0000_0001_0001_0000);
        wait_done("ignored start", 1'b0, 1'b1);
        idle_check("ignored start", 2 * LAT);

        // start held through done launches a back-to-back multiply.
        launch(1'b1, 32'hFFFF_FF00, 32'h0000_0100, 64'hFFFF_FFFF_FFFF_0000);
        wait_done("b2b first", 1'b1, 1'b0);
        launch(1'b1, 32'hFFFF_FF00, 32'h0000_0100, 64'hFFFF_FFFF_FFFF_0000);
        wait_done("b2b second", 1'b0, 1'b0);
        idle_check("b2b", 4);

        // Reset during CALC aborts without a done pulse.
        sgn   = 1'b0;
        x     = 32'h0000_1234;
        y     = 32'h0000_5678;
        start = 1'b1;
        n     = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy/done", {62'b0, busy, done}, 64'd0);
        chk("abort result", {hi, lo}, 64'd0);
        rst      = 1'b0;
        last_res = '0;
        idle_check("abort", 2 * LAT);
        launch(1'b0, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060);
        wait_done("after abort", 1'b0, 1'b0);

        chk("queue drained", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
